nibble_add_sched: RTL



---
 rtl/nibble_add_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/nibble_add_sched.sv
// Two-requester W-bit adder time-sharing one 4-bit slice, LSB nibble first.
// Optional overflow output enabled by defining NIBBLE_ADD_SCHED_OVF_EN.
module nibble_add_sched #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id
`ifdef NIBBLE_ADD_SCHED_OVF_EN
  ,
  output logic         rsp_ovf
`endif
);

  localparam int NIB = W / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  // Handshake: a transfer happens on the rising edge where valid && ready are
  // both high; ready is a combinational function of state and the valids.
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cout_q, cout_d;
  logic          valid_q, valid_d;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic          gnt0, gnt1;
  logic [3:0]    a_nib, b_nib;
  logic [4:0]    nib_sum;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    cout_d     = cout_q;
    valid_d    = valid_q;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
    ovf_d      = ovf_q;
`endif
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    gnt0       = req0_valid && (!req1_valid || last_q);
    gnt1       = req1_valid && (!req0_valid || !last_q);
    a_nib      = a_q[4*cnt_q +: 4];
    b_nib      = b_q[4*cnt_q +: 4];
    nib_sum    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};

    case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          id_d    = gnt1;
          last_d  = gnt1;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[4*cnt_q +: 4] = nib_sum[3:0];
        carry_d             = nib_sum[4];
        if (cnt_q == CNT_LAST) begin
          cout_d  = nib_sum[4];
`ifdef NIBBLE_ADD_SCHED_OVF_EN
          // carry into the MSB is a^b^sum at that bit
          ovf_d   = a_nib[3] ^ b_nib[3] ^ nib_sum[3] ^ nib_sum[4];
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // First DONE cycle registers the response; it is presented the cycle after.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;
`ifdef NIBBLE_ADD_SCHED_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif

endmodule
